uart_tx_fifo_drain: RTL and testbench

//  Downstream consumer of the 8-bit byte FIFO on the Arty7 board. Pops one byte at a time
//  (pulse fifo_rd_en, capture fifo_data one cycle later) and serialises it on the UART TX pin.

---
 rtl/uart_tx_fifo_drain_if.sv | 44 ++++
 rtl/uart_tx_fifo_drain.sv | 157 +++++++++++++++
 tb/tb_uart_tx_fifo_drain.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_drain_if.sv
// uart_tx_fifo_drain_if
//   Groups the FIFO read port, the transmit gate and the UART status signals
//   that uart_tx_fifo_drain uses.
//   Parameter: DATA_WIDTH - FIFO byte width.
//   Signals:
//     tx_enable   1 = new frames may start
//     fifo_empty  1 = FIFO holds no data
//     fifo_data   FIFO registered read data, valid the cycle after fifo_rd_en
//     fifo_rd_en  one-cycle pop request to the FIFO
//     tx          UART serial line, idle high
//     busy        transmitter is not idle
//     frame_done  one-cycle pulse on the last stop-bit cycle
//   Modports: master = the drain/transmitter, slave = FIFO + line side.
interface uart_tx_fifo_drain_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  tx_enable;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  fifo_rd_en;
  logic                  tx;
  logic                  busy;
  logic                  frame_done;

  modport master (
    input  tx_enable,
    input  fifo_empty,
    input  fifo_data,
    output fifo_rd_en,
    output tx,
    output busy,
    output frame_done
  );

  modport slave (
    output tx_enable,
    output fifo_empty,
    output fifo_data,
    input  fifo_rd_en,
    input  tx,
    input  busy,
    input  frame_done
  );
endinterface

// File: rtl/uart_tx_fifo_drain.sv
// uart_tx_fifo_drain
//   Pops bytes one at a time from the byte FIFO and serialises each as an
//   8N1 (or 8E1) UART frame, LSB first.
//   Parameters:
//     DATA_WIDTH    byte width, must match the FIFO
//     CLKS_PER_BIT  clk cycles per UART bit (2..65535)
//   Ports:
//     clk  rising-edge system clock
//     rst  synchronous active-high reset (aborts any frame in flight)
//     bus  uart_tx_fifo_drain_if.master: tx_enable, fifo_empty, fifo_data in;
//          fifo_rd_en, tx, busy, frame_done out (all registered)
//   Build option:
//     UART_TX_PARITY_EN  when defined, an even-parity bit is sent between the
//                        last data bit and the stop bit (11-bit frame).
module uart_tx_fifo_drain #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                   clk,
  input  logic                   rst,
  uart_tx_fifo_drain_if.master   bus
);

  localparam int                   BIT_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [15:0]          CLK_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0]          CLK_DONE  = 16'(CLKS_PER_BIT - 2);
  localparam logic [BIT_CNT_W-1:0] BIT_LAST  = BIT_CNT_W'(DATA_WIDTH - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, REQ, WAIT, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, REQ, WAIT, START, DATA, STOP} state_t;
`endif

  state_t                state;
  logic [15:0]           clk_cnt;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic                  tx_q;
  logic                  rd_en_q;
  logic                  busy_q;
  logic                  done_q;
`ifdef UART_TX_PARITY_EN
  logic                  parity_bit;
`endif

  assign bus.tx         = tx_q;
  assign bus.fifo_rd_en = rd_en_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = done_q;

  // Data register: loaded while the FIFO read data is valid (WAIT), shifted
  // at the end of every data bit so that shift_reg[1] is always the next bit.
  always_ff @(posedge clk) begin
    if (state == WAIT) begin
      shift_reg  <= bus.fifo_data;
`ifdef UART_TX_PARITY_EN
      parity_bit <= ^bus.fifo_data;
`endif
    end else if (state == DATA && clk_cnt == CLK_LAST) begin
      shift_reg <= shift_reg >> 1;
    end
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      clk_cnt <= '0;
      bit_cnt <= '0;
      tx_q    <= 1'b1;
      rd_en_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      rd_en_q <= 1'b0;
      done_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.tx_enable && !bus.fifo_empty) begin
            state   <= REQ;
            rd_en_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        REQ: begin
          state <= WAIT;
        end
        // FIFO data is valid this cycle; shift_reg captures it on this edge.
        WAIT: begin
          state   <= START;
          tx_q    <= 1'b0;
          clk_cnt <= '0;
        end
        START: begin
          if (clk_cnt == CLK_LAST) begin
            clk_cnt <= '0;
            bit_cnt <= '0;
            state   <= DATA;
            tx_q    <= shift_reg[0];
          end else begin
            clk_cnt <= clk_cnt + 16'd1;
          end
        end
        DATA: begin
          if (clk_cnt == CLK_LAST) begin
            clk_cnt <= '0;
            if (bit_cnt == BIT_LAST) begin
              bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
              state   <= PARITY;
              tx_q    <= parity_bit;
`else
              state   <= STOP;
              tx_q    <= 1'b1;
`endif
            end else begin
              bit_cnt <= bit_cnt + BIT_CNT_W'(1);
              tx_q    <= shift_reg[1];
            end
          end else begin
            clk_cnt <= clk_cnt + 16'd1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (clk_cnt == CLK_LAST) begin
            clk_cnt <= '0;
            state   <= STOP;
            tx_q    <= 1'b1;
          end else begin
            clk_cnt <= clk_cnt + 16'd1;
          end
        end
`endif
        // frame_done is raised one edge early so the registered pulse lands
        // on the final stop-bit cycle.
        STOP: begin
          if (clk_cnt == CLK_LAST) begin
            clk_cnt <= '0;
            state   <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            clk_cnt <= clk_cnt + 16'd1;
            done_q  <= (clk_cnt == CLK_DONE);
          end
        end
        default: begin
          state  <= IDLE;
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// tb_uart_tx_fifo_drain
//   Drives uart_tx_fifo_drain from a queue-based FIFO model. Popped bytes go
//   into a scoreboard; an independent monitor decodes the tx line as a UART
//   receiver and checks each frame, the pop rule, reset state and timing.
module tb_uart_tx_fifo_drain;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FBITS = 11;
`else
  localparam int FBITS = 10;
`endif
  localparam int FLEN = FBITS * CPB;

  logic clk = 1'b0;
  logic rst;

  uart_tx_fifo_drain_if #(.DATA_WIDTH(8)) bus ();

  uart_tx_fifo_drain #(
    .DATA_WIDTH   (8),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  bit         pop_pending = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected line levels of one frame, one entry per bit period.
  function automatic logic [FBITS-1:0] frame_of(input logic [7:0] b);
    logic [FBITS-1:0] f;
    f    = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = b[i];
`ifdef UART_TX_PARITY_EN
    f[9] = ^b;
`endif
    return f;
  endfunction

  // One clock of stimulus; also acts as the FIFO: a pop seen in cycle r
  // presents its data in cycle r+1.
  task automatic step();
    @(posedge clk);
    #1;
    if (pop_pending) begin
      check("pop_nonempty", 32'(fifo_q.size() > 0), 32'd1);
      if (fifo_q.size() > 0) begin
        bus.fifo_data = fifo_q.pop_front();
        exp_q.push_back(bus.fifo_data);
      end
      pop_pending = 1'b0;
    end
    if (bus.fifo_rd_en === 1'b1) pop_pending = 1'b1;
    bus.fifo_empty = (fifo_q.size() == 0);
  endtask

  task automatic push_byte(input logic [7:0] b);
    fifo_q.push_back(b);
    bus.fifo_empty = 1'b0;
  endtask

  task automatic wait_idle(input int bound, input bit need_empty);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!((!need_empty || fifo_q.size() == 0) && !pop_pending &&
                 bus.fifo_rd_en !== 1'b1 && bus.busy === 1'b0) && n < bound);
    check("drain_idle", {30'd0, bus.busy, need_empty && fifo_q.size() != 0}, 32'd0);
  endtask

  task automatic wait_tx_low(input int bound);
    int n;
    n = 0;
    while (bus.tx !== 1'b0 && n < bound) begin
      step();
      n++;
    end
    check("start_seen", 32'(bus.tx), 32'd0);
  endtask

  // Monitor: pop rule, reset state, UART frame decode.
  int               cyc = 0;
  int               last_rd_cyc = -100;
  bit               have_prev = 1'b0;
  bit               exp_rd = 1'b0;
  bit               prev_rst = 1'b0;
  bit               in_frame = 1'b0;
  bit               chk_idle = 1'b0;
  bit               hold_err, fd_err, busy_err;
  int               fpos;
  logic [FBITS-1:0] rx;
  logic [7:0]       cur;

  always @(negedge clk) begin
    int b;
    cyc++;
    if (have_prev) check("rd_en", 32'(bus.fifo_rd_en), 32'(exp_rd));
    have_prev = 1'b1;
    exp_rd = (rst === 1'b0) && (bus.busy === 1'b0) && (bus.tx_enable === 1'b1) &&
             (bus.fifo_empty === 1'b0);
    if (bus.fifo_rd_en === 1'b1) last_rd_cyc = cyc;
    if (prev_rst) begin
      check("reset_tx", 32'(bus.tx), 32'd1);
      check("reset_busy", 32'(bus.busy), 32'd0);
      check("reset_frame_done", 32'(bus.frame_done), 32'd0);
    end
    prev_rst = (rst === 1'b1);
    if (rst === 1'b1) begin
      in_frame = 1'b0;
      chk_idle = 1'b0;
    end else begin
      if (!in_frame) begin
        if (chk_idle) begin
          check("busy_after_frame", 32'(bus.busy), 32'd0);
          chk_idle = 1'b0;
        end
        check("idle_frame_done", 32'(bus.frame_done), 32'd0);
        if (bus.tx === 1'b0) begin
          check("start_latency", 32'(cyc - last_rd_cyc), 32'd2);
          check("frame_expected", 32'(exp_q.size() > 0), 32'd1);
          cur      = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
          in_frame = 1'b1;
          fpos     = 0;
          hold_err = 1'b0;
          fd_err   = 1'b0;
          busy_err = 1'b0;
          rx       = '1;
        end
      end
      if (in_frame) begin
        b = fpos / CPB;
        if (fpos % CPB == 0) rx[b] = bus.tx;
        else if (bus.tx !== rx[b]) hold_err = 1'b1;
        if (bus.frame_done !== (fpos == FLEN - 1)) fd_err = 1'b1;
        if (bus.busy !== 1'b1) busy_err = 1'b1;
        if (fpos == FLEN - 1) begin
          check("frame_bits", 32'(rx), 32'(frame_of(cur)));
          check("bit_hold", 32'(hold_err), 32'd0);
          check("frame_done_pos", 32'(fd_err), 32'd0);
          check("busy_in_frame", 32'(busy_err), 32'd0);
          in_frame = 1'b0;
          chk_idle = 1'b1;
        end else begin
          fpos++;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst            = 1'b1;
    bus.tx_enable  = 1'b1;
    bus.fifo_empty = 1'b1;
    bus.fifo_data  = 8'h00;

    // Reset held with data waiting, then the 0xA5 frame.
    push_byte(8'hA5);
    step();
    step();
    rst = 1'b0;
    wait_idle(400, 1'b1);

    // Back-to-back frames.
    push_byte(8'h00);
    push_byte(8'hFF);
    wait_idle(400, 1'b1);

    // Hold-off, then disable during data bit 3.
    bus.tx_enable = 1'b0;
    push_byte(8'h5A);
    repeat (50) step();
    check("hold_off_pop", 32'(fifo_q.size()), 32'd1);
    push_byte(8'h96);
    bus.tx_enable = 1'b1;
    wait_tx_low(50);
    repeat (17) step();
    bus.tx_enable = 1'b0;
    wait_idle(200, 1'b0);
    repeat (20) step();
    check("no_pop_disabled", 32'(fifo_q.size()), 32'd1);
    bus.tx_enable = 1'b1;
    wait_idle(400, 1'b1);

    // Reset during data bit 4 of 0x3C, then a clean restart.
    push_byte(8'h3C);
    wait_tx_low(50);
    repeat (21) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    push_byte(8'h81);
    wait_idle(400, 1'b1);

    // Parity-sensitive bytes.
    push_byte(8'h07);
    push_byte(8'h03);
    wait_idle(400, 1'b1);

    // Randomised traffic with tx_enable toggling.
    for (int it = 0; it < 25; it++) begin
      int nb;
      int gap;
      nb = $urandom_range(1, 3);
      for (int k = 0; k < nb; k++) push_byte(8'($urandom));
      gap = $urandom_range(0, 60);
      for (int k = 0; k < gap; k++) begin
        bus.tx_enable = ($urandom_range(0, 3) != 0);
        step();
      end
    end
    bus.tx_enable = 1'b1;
    wait_idle(6000, 1'b1);

    repeat (5) step();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
